// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART blocks. This package holds the receiver state encoding,
// the default bit period for 115200 baud at 100 MHz, and the frame width that the holding
// register and the future transmitter also use.
`timescale 1ns/1ps
package uart_pkg;

   // 100 MHz / 115200 baud
   localparam int unsigned CLKS_PER_BIT = 868;

   // Data bits per frame; the holding register is this wide
   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. Both flops reset to RESET_VAL so
// that the synchronized output shows the line's idle level straight out of reset. The TX
// block can reuse it as well.
//
// Ports:
//   clk    destination clock
//   reset  asynchronous, active-low reset
//   d      asynchronous input
//   q      synchronized output (second flop)
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 asynchronous serial receiver, LSB first. Each bit is sampled once, in the middle of
// its bit period. A good frame loads rx_data and pulses rx_valid for one cycle. A low stop
// bit pulses frame_err for one cycle, and the FSM then waits for the line to go high again
// so that a held-low line is not read again as a new start bit.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   rx         serial line, asynchronous to clk, idle high
//   rx_data    last correctly framed byte; holds until the next good frame
//   rx_valid   one-cycle pulse when rx_data updates
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   busy       high whenever the FSM is not in IDLE
`timescale 1ns/1ps
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   import uart_pkg::*;

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_t            state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (rx),
      .q    (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         // Pulses last one cycle unless a branch below sets them again
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= '0;
                  state <= START;
               end
            end

            START: begin
               // Check the start bit again at half a bit period to reject glitches
               if (cnt == CNT_HALF) begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     cnt     <= '0;
                     bit_idx <= '0;
                     state   <= DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == CNT_LAST) begin
                  // Right shift: the first bit received ends up in the LSB
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
                  cnt     <= '0;
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               // Return at mid-stop-bit so that a back-to-back start edge is caught
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Decoded straight from the state register, so busy falls on the same edge as the
   // rx_valid pulse
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx at CLKS_PER_BIT=16. It drives complete 8N1 frames bit by bit
// and uses a negedge monitor to log the rx_valid and frame_err pulses. Expected values are
// worked out by hand from the frame timing: the stop-bit sample, and with it rx_valid,
// lands 155 cycles after the start edge is driven.
`timescale 1ns/1ps
module tb_uart_rx;

   import uart_pkg::*;

   localparam int unsigned CPB = 16;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Downstream holding register model
   logic [7:0] hold;
   always @(posedge clk or negedge reset) begin
      if (!reset) hold <= 8'h00;
      else if (rx_valid) hold <= rx_data;
   end

   // Pulse monitor
   int         valid_cnt  = 0;
   int         ferr_cnt   = 0;
   int         overlap    = 0;
   int         long_pulse = 0;
   int         valid_cyc[$];
   logic [7:0] valid_dat[$];
   logic       prev_v      = 1'b0;
   logic       prev_f      = 1'b0;
   logic       prev_busy   = 1'b0;
   logic       busy_at_v   = 1'b1;
   logic       busy_before = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt   <= valid_cnt + 1;
         valid_cyc.push_back(cycle);
         valid_dat.push_back(rx_data);
         busy_at_v   <= busy;
         busy_before <= prev_busy;
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_valid && frame_err) overlap <= overlap + 1;
      if ((rx_valid && prev_v) || (frame_err && prev_f)) long_pulse <= long_pulse + 1;
      prev_v    <= rx_valid;
      prev_f    <= frame_err;
      prev_busy <= busy;
   end

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int per);
      drive_bit(1'b0, per);
      for (int i = 0; i < 8; i++) drive_bit(d[i], per);
      drive_bit(stop, per);
   endtask

   // Bit periods alternate 17/15 cycles, averaging the nominal 16
   task automatic send_jitter(input logic [7:0] d);
      drive_bit(1'b0, 15);
      for (int i = 0; i < 8; i++) drive_bit(d[i], (i % 2 == 0) ? 17 : 15);
      drive_bit(1'b1, 17);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   int v0;
   int f0;
   int c0;
   int n;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_sync_idle", 32'(dut.rx_s), 32'h1);
      reset = 1'b1;
      idle(4);

      // Good frame 0xA5
      v0 = valid_cnt;
      c0 = cycle;
      send_frame(8'hA5, 1'b1, CPB);
      idle(4);
      n = valid_dat.size();
      check("a5_pulses", 32'(valid_cnt - v0), 32'd1);
      check("a5_rx_data", 32'(rx_data), 32'hA5);
      check("a5_latency", 32'(valid_cyc[n-1] - c0), 32'd155);
      check("a5_busy_at_valid", 32'(busy_at_v), 32'h0);
      check("a5_busy_before", 32'(busy_before), 32'h1);
      check("a5_no_ferr", 32'(ferr_cnt), 32'd0);
      check("a5_hold", 32'(hold), 32'hA5);

      // Glitch: 4 cycles low
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_bit(1'b0, 4);
      check("glitch_busy", 32'(busy), 32'h1);
      idle(30);
      check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("glitch_rx_data", 32'(rx_data), 32'hA5);
      check("glitch_idle", 32'(busy), 32'h0);

      // Framing error: 0x3C with low stop bit, then line held low
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, CPB);
      drive_bit(1'b0, 40);
      check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
      check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("ferr_rx_data", 32'(rx_data), 32'hA5);
      check("ferr_busy", 32'(busy), 32'h1);
      check("ferr_state", 32'(dut.state), 32'(BREAK));
      idle(8);
      check("ferr_recover", 32'(busy), 32'h0);
      send_frame(8'h81, 1'b1, CPB);
      idle(4);
      check("after_ferr_data", 32'(rx_data), 32'h81);
      check("after_ferr_pulse", 32'(valid_cnt - v0), 32'd1);

      // Back-to-back 0x00, 0xFF
      v0 = valid_cnt;
      send_frame(8'h00, 1'b1, CPB);
      send_frame(8'hFF, 1'b1, CPB);
      idle(4);
      n = valid_dat.size();
      check("b2b_pulses", 32'(valid_cnt - v0), 32'd2);
      check("b2b_first", 32'(valid_dat[n-2]), 32'h00);
      check("b2b_second", 32'(valid_dat[n-1]), 32'hFF);
      check("b2b_spacing", 32'(valid_cyc[n-1] - valid_cyc[n-2]), 32'd160);
      check("b2b_hold", 32'(hold), 32'hFF);

      // Reset during bit 3 of 0x55
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_bit(1'b0, CPB);
      drive_bit(1'b1, CPB);
      drive_bit(1'b0, CPB);
      drive_bit(1'b1, CPB);
      rx = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_rx_data", 32'(rx_data), 32'h00);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_valid", 32'(rx_valid), 32'h0);
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(20);
      check("mid_rst_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("mid_rst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      send_frame(8'h55, 1'b1, CPB);
      idle(4);
      check("after_rst_data", 32'(rx_data), 32'h55);
      check("after_rst_pulse", 32'(valid_cnt - v0), 32'd1);

      // Bit-period tolerance
      send_frame(8'h96, 1'b1, 17);
      idle(8);
      check("slow_17_data", 32'(rx_data), 32'h96);
      send_frame(8'h00, 1'b1, CPB);
      idle(4);
      check("reload_00", 32'(rx_data), 32'h00);
      v0 = valid_cnt;
      send_jitter(8'h96);
      idle(8);
      check("jitter_data", 32'(rx_data), 32'h96);
      check("jitter_pulse", 32'(valid_cnt - v0), 32'd1);

      // Global pulse rules
      check("no_overlap", 32'(overlap), 32'd0);
      check("single_cycle_pulses", 32'(long_pulse), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 framing, LSB first.
- Sits directly upstream of the UART holding register.
- rx_data drives the register's data_in; rx_valid drives its enable. One received byte is loaded per valid frame.
- Also flags framing errors and reports a busy status.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range >= 4.
- DATA_BITS, 8, data bits per frame; must match the holding register width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  DATA_BITS  last correctly framed byte; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, counters=0, shift register=0.
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - Both synchronizer flops reset to 1, the idle line level.
- Input path:
  - rx passes through a 2-flop synchronizer; rx_s is the second flop.
  - All decisions use rx_s.
- State machine (states IDLE, START, DATA, STOP, BREAK):
  - IDLE: when rx_s==0, clear cnt, go START.
  - START: count. At cnt==(CLKS_PER_BIT-1)/2, sample rx_s:
    - rx_s==1: glitch; return to IDLE with no outputs.
    - rx_s==0: clear cnt, bit_idx=0, go DATA.
  - DATA: at cnt==CLKS_PER_BIT-1:
    - Shift rx_s into the MSB of the shift register (right shift, so the first bit ends at LSB).
    - bit_idx++ and cnt=0.
    - After DATA_BITS samples, go STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - 1: rx_data <= shift register; rx_valid=1 for the next cycle only; go IDLE.
    - 0: frame_err=1 for the next cycle only; rx_data unchanged; go BREAK.
  - BREAK: stay until rx_s==1, then IDLE. This prevents a held-low line from being re-read as a start bit.
- Sampling and timing:
  - Every bit is sampled mid-period: the half-bit offset in START plus full periods thereafter.
  - Latency: rx_valid rises 2 sync cycles + about (DATA_BITS+1.5)*CLKS_PER_BIT cycles after the start-bit falling edge on rx.
  - Returning to IDLE at mid-stop-bit lets a back-to-back frame start immediately.
- Pulse and data rules:
  - rx_valid and frame_err are registered, never both high, and never high longer than one cycle.
  - cnt width is $clog2(CLKS_PER_BIT); bit_idx width is $clog2(DATA_BITS+1). Neither wraps within a frame.
  - A line change on rx mid-bit is ignored; only the mid-point sample matters.
- Reset mid-frame: the frame is discarded with no pulse on rx_valid or frame_err; the FSM restarts in IDLE.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - the default CLKS_PER_BIT constant;
  - DATA_BITS=8, shared with the holding register and the future TX.
- One natural sub-module, sync_2ff: a parameterised-reset-value 2-flop synchronizer, reusable by the TX block.
- Bit counter, shift register and FSM stay in uart_rx.

Test Plan:
- Simulate with CLKS_PER_BIT=16.
- Good frame: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly one rx_valid pulse; rx_data=0xA5; frame_err stays 0; busy falls the same cycle rx_valid rises.
- Glitch: rx low for 4 cycles then high -> START aborts to IDLE; no rx_valid or frame_err; rx_data keeps its prior value.
- Framing error: send 0x3C with stop bit 0, line held low 40 cycles -> one frame_err pulse; rx_data unchanged; FSM in BREAK until rx high. Next good 0x81 -> rx_data=0x81.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two rx_valid pulses exactly 10*16 cycles apart, rx_data 0x00 then 0xFF. Register downstream captures both.
- Reset mid-frame: assert reset during bit 3 of 0x55 -> outputs 0 immediately (asynchronous); no pulses. After release, a full 0x55 frame -> rx_data=0x55.
- Bit-period tolerance: send 0x96 with bit periods of 15 and 17 cycles -> rx_data=0x96 in both cases.
